// File: rtl/dma_wr_sched_if.sv
// Requester/engine bundle for dma_wr_sched: job handshake, data steering and engine control.
interface dma_wr_sched_if #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned OUT_BITS_TRANS = 13,
  parameter int unsigned AXI_WIDTH_AD   = 32,
  parameter int unsigned AXI_WIDTH_DA   = 32
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ*AXI_WIDTH_AD-1:0]   req_addr;
  logic [NUM_REQ*OUT_BITS_TRANS-1:0] req_len;
  logic [NUM_REQ*AXI_WIDTH_DA-1:0]   req_data;
  logic [NUM_REQ-1:0]                req_data_rd;
  logic [NUM_REQ-1:0]                req_done;
  logic                              req_err;
  logic                              dma_start;
  logic [OUT_BITS_TRANS-1:0]         dma_num_trans;
  logic [AXI_WIDTH_AD-1:0]           dma_start_addr;
  logic [AXI_WIDTH_DA-1:0]           dma_indata;
  logic                              dma_indata_req;
  logic                              dma_done;
  logic                              dma_fail;

  // Scheduler side
  modport slave (
    input  req_valid, req_addr, req_len, req_data, dma_indata_req, dma_done, dma_fail,
    output req_ready, req_data_rd, req_done, req_err,
           dma_start, dma_num_trans, dma_start_addr, dma_indata
  );

  // Requesters + engine side
  modport master (
    output req_valid, req_addr, req_len, req_data, dma_indata_req, dma_done, dma_fail,
    input  req_ready, req_data_rd, req_done, req_err,
           dma_start, dma_num_trans, dma_start_addr, dma_indata
  );
endinterface

// File: rtl/dma_wr_sched.sv
// Round-robin scheduler sharing one AXI write DMA engine among NUM_REQ producers.
// Define DMA_WR_SCHED_ERR_CNT_EN to enable the saturating err_cnt failure counter.
module dma_wr_sched #(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned OUT_BITS_TRANS = 13,
  parameter  int unsigned AXI_WIDTH_AD   = 32,
  parameter  int unsigned AXI_WIDTH_DA   = 32,
  localparam int unsigned GW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  dma_wr_sched_if.slave        bus,
  output logic                 busy,
  output logic [GW-1:0]        grant_idx,
  output logic [15:0]          err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_RESP} state_e;

  state_e                    state_q, state_d;
  logic [GW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [OUT_BITS_TRANS-1:0] num_q, num_d;
  logic [AXI_WIDTH_AD-1:0]   addr_q, addr_d;
  logic                      err_flag_q, err_flag_d;

  logic                      found;
  logic [GW-1:0]             win;
  logic [GW-1:0]             idx_g;
  int unsigned               idx;
  logic [OUT_BITS_TRANS-1:0] win_len;
  logic [AXI_WIDTH_AD-1:0]   win_addr;
  logic [GW-1:0]             ptr_next;

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_g = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(rr_ptr_q) + k) % NUM_REQ;
      idx_g = GW'(idx);
      if (!found && bus.req_valid[idx_g]) begin
        found = 1'b1;
        win   = idx_g;
      end
    end
  end

  assign win_len  = bus.req_len[win*OUT_BITS_TRANS +: OUT_BITS_TRANS];
  assign win_addr = bus.req_addr[win*AXI_WIDTH_AD +: AXI_WIDTH_AD];
  assign ptr_next = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    num_d          = num_q;
    addr_d         = addr_q;
    err_flag_d     = err_flag_q;
    bus.req_ready  = '0;
    bus.req_data_rd = '0;
    bus.req_done   = '0;
    bus.req_err    = 1'b0;
    bus.dma_start  = 1'b0;
    bus.dma_indata = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          bus.req_ready[win] = 1'b1;
          grant_d = win;
          num_d   = win_len;
          addr_d  = win_addr;
          state_d = (win_len == '0) ? S_RESP : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        bus.dma_start = 1'b1;
        state_d       = S_BUSY;
      end
      S_BUSY: begin
        bus.dma_indata           = bus.req_data[grant_q*AXI_WIDTH_DA +: AXI_WIDTH_DA];
        bus.req_data_rd[grant_q] = bus.dma_indata_req;
        if (bus.dma_fail) err_flag_d = 1'b1;
        if (bus.dma_done) state_d = S_RESP;
      end
      S_RESP: begin
        bus.req_done[grant_q] = 1'b1;
        bus.req_err           = err_flag_q;
        err_flag_d            = 1'b0;
        rr_ptr_d              = ptr_next;
        state_d               = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      num_q      <= '0;
      addr_q     <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      num_q      <= num_d;
      addr_q     <= addr_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign bus.dma_num_trans  = num_q;
  assign bus.dma_start_addr = addr_q;
  assign busy               = (state_q != S_IDLE);
  assign grant_idx          = grant_q;

`ifdef DMA_WR_SCHED_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == S_BUSY && bus.dma_fail && err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dma_wr_sched.sv
// Directed self-checking bench for dma_wr_sched: single job, round-robin order, zero length,
// failure reporting, out-of-state engine pulses and mid-job reset.
module tb_dma_wr_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned LW = 13;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef DMA_WR_SCHED_ERR_CNT_EN
  localparam logic [15:0] EXP_ERRCNT = 16'd2;
`else
  localparam logic [15:0] EXP_ERRCNT = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [1:0]  grant_idx;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  dma_wr_sched_if #(.NUM_REQ(NR), .OUT_BITS_TRANS(LW), .AXI_WIDTH_AD(AW), .AXI_WIDTH_DA(DW)) bus ();

  dma_wr_sched #(.NUM_REQ(NR), .OUT_BITS_TRANS(LW), .AXI_WIDTH_AD(AW), .AXI_WIDTH_DA(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .grant_idx (grant_idx),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int rd_cnt;
  int idle;
  bit got;
  logic [1:0] exp_rr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst                = 1'b1;
    bus.req_valid      = '0;
    bus.req_addr       = '0;
    bus.req_len        = '0;
    bus.req_data       = '0;
    bus.dma_indata_req = 1'b0;
    bus.dma_done       = 1'b0;
    bus.dma_fail       = 1'b0;
    repeat (3) tick();
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_start", bus.dma_start, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_num", bus.dma_num_trans, 0);
    chk("rst_addr", bus.dma_start_addr, 0);
    chk("rst_done", bus.req_done, 0);
    rst = 1'b0;

    // Single job, requester 2, 300 words
    tick();
    bus.req_valid = 4'b0100;
    bus.req_addr[2*AW +: AW] = 32'h1000_0000;
    bus.req_len[2*LW +: LW]  = 13'd300;
    settle();
    chk("t1_ready", bus.req_ready, 4'b0100);
    chk("t1_idle", busy, 0);
    tick();
    bus.req_valid = '0;
    settle();
    chk("t1_start", bus.dma_start, 1);
    chk("t1_num", bus.dma_num_trans, 300);
    chk("t1_addr", bus.dma_start_addr, 32'h1000_0000);
    chk("t1_grant", grant_idx, 2);
    chk("t1_ready_launch", bus.req_ready, 0);
    tick();
    settle();
    chk("t1_start_once", bus.dma_start, 0);
    chk("t1_busy", busy, 1);
    rd_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      bus.dma_indata_req = ((c % 4) != 3) && (rd_cnt < 300);
      bus.req_data[2*DW +: DW] = 32'hA500_0000 + 32'(c);
      bus.req_data[1*DW +: DW] = 32'hDEAD_0000 + 32'(c);
      settle();
      chk("t1_rd", bus.req_data_rd, bus.dma_indata_req ? 4'b0100 : 4'b0000);
      chk("t1_data", bus.dma_indata, 32'hA500_0000 + 32'(c));
      if (bus.req_data_rd[2]) rd_cnt++;
    end
    tick();
    bus.dma_indata_req = 1'b0;
    bus.dma_done = 1'b1;
    settle();
    chk("t1_rd_count", rd_cnt, 300);
    tick();
    bus.dma_done = 1'b0;
    settle();
    chk("t1_done", bus.req_done, 4'b0100);
    chk("t1_err", bus.req_err, 0);
    chk("t1_indata_resp", bus.dma_indata, 0);
    tick();
    settle();
    chk("t1_done_once", bus.req_done, 0);
    chk("t1_idle_after", busy, 0);

    // Round-robin with all requesters valid from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.req_len[i*LW +: LW]  = 13'd2;
      bus.req_addr[i*AW +: AW] = 32'(i) * 32'h100;
    end
    for (int j = 0; j < 5; j++) begin
      idle = 0;
      got  = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        settle();
        if (!busy) idle++;
        if (bus.dma_start) got = 1'b1;
      end
      chk("t2_launch_seen", got, 1);
      chk("t2_grant", grant_idx, exp_rr[j]);
      chk("t2_addr", bus.dma_start_addr, 32'(exp_rr[j]) * 32'h100);
      if (j > 0) chk("t2_gap", idle, 1);
      tick();
      bus.dma_done = 1'b1;
      tick();
      bus.dma_done = 1'b0;
      settle();
      chk("t2_done", bus.req_done, 4'b0001 << exp_rr[j]);
    end
    bus.req_valid = '0;
    tick();
    settle();

    // Zero-length job, requester 1
    bus.req_valid = 4'b0010;
    bus.req_len[1*LW +: LW] = 13'd0;
    settle();
    chk("t3_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    settle();
    chk("t3_done", bus.req_done, 4'b0010);
    chk("t3_err", bus.req_err, 0);
    chk("t3_no_start", bus.dma_start, 0);
    tick();
    settle();
    chk("t3_idle", busy, 0);
    chk("t3_no_start2", bus.dma_start, 0);

    // 512-word job on requester 3 with two failed bursts
    bus.req_valid = 4'b1000;
    bus.req_len[3*LW +: LW]  = 13'd512;
    bus.req_addr[3*AW +: AW] = 32'h2000_0000;
    settle();
    chk("t4_ready", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    settle();
    chk("t4_num", bus.dma_num_trans, 512);
    for (int w = 0; w < 512; w++) begin
      tick();
      bus.dma_indata_req = 1'b1;
      bus.dma_fail = (w == 100) || (w == 511);
      bus.dma_done = (w == 511);
    end
    tick();
    bus.dma_indata_req = 1'b0;
    bus.dma_fail = 1'b0;
    bus.dma_done = 1'b0;
    settle();
    chk("t4_done", bus.req_done, 4'b1000);
    chk("t4_err", bus.req_err, 1);
    chk("t4_errcnt", err_cnt, EXP_ERRCNT);
    tick();
    bus.req_valid = 4'b0001;
    bus.req_len[0*LW +: LW] = 13'd5;
    settle();
    chk("t4b_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    bus.dma_done = 1'b1;
    tick();
    bus.dma_done = 1'b0;
    settle();
    chk("t4b_done", bus.req_done, 4'b0001);
    chk("t4b_err", bus.req_err, 0);
    tick();

    // Engine pulses while idle are ignored
    bus.dma_done = 1'b1;
    bus.dma_fail = 1'b1;
    settle();
    chk("t6_idle", busy, 0);
    tick();
    bus.dma_done = 1'b0;
    bus.dma_fail = 1'b0;
    settle();
    chk("t6_busy", busy, 0);
    chk("t6_done", bus.req_done, 0);
    chk("t6_errcnt", err_cnt, EXP_ERRCNT);
    tick();
    settle();
    chk("t6_done2", bus.req_done, 0);

    // Reset in the middle of a job
    bus.req_valid = 4'b0100;
    bus.req_len[2*LW +: LW] = 13'd10;
    tick();
    bus.req_valid = '0;
    tick();
    bus.dma_indata_req = 1'b1;
    settle();
    chk("t5_rd_busy", bus.req_data_rd, 4'b0100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t5_busy", busy, 0);
    chk("t5_start", bus.dma_start, 0);
    chk("t5_rd", bus.req_data_rd, 0);
    chk("t5_indata", bus.dma_indata, 0);
    chk("t5_done", bus.req_done, 0);
    chk("t5_err", bus.req_err, 0);
    chk("t5_grant", grant_idx, 0);
    chk("t5_num", bus.dma_num_trans, 0);
    chk("t5_addr", bus.dma_start_addr, 0);
    chk("t5_errcnt", err_cnt, 0);
    bus.dma_indata_req = 1'b0;
    bus.req_valid = 4'b1111;
    settle();
    chk("t5_ptr", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    settle();
    chk("t5_launch_done", bus.req_done, 0);
    chk("t5_launch_grant", grant_idx, 0);
    tick();
    bus.dma_done = 1'b1;
    tick();
    bus.dma_done = 1'b0;
    settle();
    chk("t5_job_done", bus.req_done, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_wr_sched.md
# dma_wr_sched

Round-robin scheduler that shares the single AXI4 output-write DMA engine among `NUM_REQ` output producers, such as systolic-array drain units and tile writers. It accepts one write job (address, word count) per grant and launches it on the engine with a one-cycle start pulse. While the job runs, it steers the engine's word-request/data path to the granted producer. It returns a per-requester done/error pulse when the engine finishes.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `OUT_BITS_TRANS`, 13: width of the word-count field.
- `AXI_WIDTH_AD`, 32: byte-address width.
- `AXI_WIDTH_DA`, 32: data word width.
- `GW`, $clog2(NUM_REQ): grant index width (localparam).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester job request; held until accepted.
- `req_ready`  out  NUM_REQ  one-hot accept; a job transfers when valid & ready.
- `req_addr`  in  NUM_REQ*AXI_WIDTH_AD  packed start byte addresses; slice i belongs to requester i.
- `req_len`  in  NUM_REQ*OUT_BITS_TRANS  packed word counts.
- `req_data`  in  NUM_REQ*AXI_WIDTH_DA  packed write data.
- `req_data_rd`  out  NUM_REQ  pop strobe to the granted requester's data source.
- `req_done`  out  NUM_REQ  one-cycle completion pulse.
- `req_err`  out  1  qualifies `req_done`; 1 means at least one burst failed.
- `dma_start`  out  1  one-cycle engine start.
- `dma_num_trans`  out  OUT_BITS_TRANS  latched word count.
- `dma_start_addr`  out  AXI_WIDTH_AD  latched start address.
- `dma_indata`  out  AXI_WIDTH_DA  data from the granted requester.
- `dma_indata_req`  in  1  engine word request.
- `dma_done`  in  1  engine completion pulse.
- `dma_fail`  in  1  engine per-burst bad BRESP pulse.
- `busy`  out  1  a job is in flight, i.e. the state is not S_IDLE.
- `grant_idx`  out  GW  index of the current/last granted requester.
- `err_cnt`  out  16  saturating failure count (see Configuration).

## Operation
States:
- S_IDLE: if any `req_valid` is high, select a winner by round-robin and assert `req_ready[w]` combinationally in the same cycle. On the handshake, latch `req_addr`/`req_len` slice w and set `grant_idx`=w.
  - len≠0 → S_LAUNCH.
  - len==0 → S_RESP. The engine is never started.
- S_LAUNCH: `dma_start`=1 for exactly one cycle → S_BUSY.
- S_BUSY:
  - `dma_indata` = `req_data` slice `grant_idx`, combinationally.
  - `req_data_rd[grant_idx]` = `dma_indata_req`, combinationally; all other bits are 0.
  - Each `dma_fail` pulse sets the sticky job-error flag.
  - On `dma_done` → S_RESP.
- S_RESP: `req_done[grant_idx]`=1 and `req_err`=sticky flag for one cycle. Clear the flag, set the RR pointer to `grant_idx`+1 (mod NUM_REQ) → S_IDLE.

Round-robin rules:
- The search starts at the pointer and wraps.
- The pointer changes only in S_RESP.
- A requester dropping `req_valid` before acceptance is legal and is simply skipped.

Datapath rules:
- `dma_num_trans`/`dma_start_addr` are registered. They hold their value from S_IDLE acceptance until the next acceptance.
- `dma_indata` = 0 and `req_data_rd` = 0 outside S_BUSY.
- `dma_done`/`dma_fail` outside S_BUSY are ignored.
- `dma_fail` in the same cycle as `dma_done` still counts toward `req_err`.
- `req_ready` is 0 in every state except S_IDLE, so at most one job is in flight.

## Timing
- Reset values: all outputs 0, state S_IDLE, RR pointer 0, `grant_idx` 0, `err_cnt` 0, sticky flag 0.
- Reset asserted mid-job: the scheduler returns to S_IDLE next cycle with no `req_done`. The system must reset the engine concurrently.
- Acceptance cycle T: `dma_start` is high at T+1, and `dma_num_trans`/`dma_start_addr` are valid from T+1.
- Zero-length job accepted at T: `req_done` at T+1.
- `dma_done` at T: `req_done` at T+1, and the earliest next acceptance is T+2.
- The data steering path is zero-latency combinational, so the engine's read-ahead semantics are preserved unchanged.

## Configuration
- `DMA_WR_SCHED_ERR_CNT_EN` defined:
  - `err_cnt` increments on every `dma_fail` seen in S_BUSY.
  - It saturates at 16'hFFFF.
  - It is cleared only by `rst`.
- Not defined: `err_cnt` is tied to 0; the port remains present. `req_err` works in both builds.

## Test plan
- Single job, requester 2, addr 0x1000_0000, len 300: `dma_start` 1 cycle after acceptance with num_trans=300. 300 `req_data_rd[2]` pulses mirror `dma_indata_req`. `req_done[2]`=1, `req_err`=0 one cycle after `dma_done`.
- All 4 requesters valid continuously from reset: grants in order 0,1,2,3,0, with `busy` low for exactly 1 cycle between jobs.
- Requester 1, len 0: `req_done[1]` on the next cycle; `dma_start` never asserted.
- Engine model pulses `dma_fail` twice during a 512-word job: `req_err`=1 with `req_done`. `err_cnt`=2 when the macro is defined, 0 when it is not. The next job reports `req_err`=0.
- `rst` asserted in S_BUSY: next cycle all outputs are 0 and the state is S_IDLE. No `req_done` is issued; the pointer returns to 0.
- `dma_done`/`dma_fail` pulsed while in S_IDLE: no state change, no `req_done`, `err_cnt` unchanged.
